// File: rtl/ifetch_queue_pkg.sv
// ============================================================================
// Module : ifetch_queue_pkg
// Brief  : Shared widths and default sizing for the instruction fetch queue.
// Rev    : 1.0
// ============================================================================
`default_nettype none

// Bus widths normally arrive from the shared defines include; defaults keep
// the package usable when it is compiled on its own.
`ifndef MYRISCV_ADDRBUS
`define MYRISCV_ADDRBUS 32
`endif
`ifndef MYRISCV_INSTBUS
`define MYRISCV_INSTBUS 32
`endif

package ifetch_queue_pkg;

    localparam int c_ADDR_W    = `MYRISCV_ADDRBUS;
    localparam int c_INSTR_W   = `MYRISCV_INSTBUS;
    localparam int c_DEPTH     = 4;
    localparam int c_MAX_OUTST = 1;

endpackage

`default_nettype wire

// File: rtl/ifq_sync_fifo.sv
// ============================================================================
// Module : ifq_sync_fifo
// Brief  : Generic synchronous FIFO with wrap-bit pointers and flush.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ifq_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_occ
);

    localparam int c_PW = $clog2(DEPTH) + 1;
    localparam int c_IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PW-1:0] c_PTR_ONE = {{(c_PW-1){1'b0}}, 1'b1};

    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic            w_push_ok;
    logic            w_pop_ok;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_occ     = r_wr_ptr - r_rd_ptr;
    assign w_pop_ok  = i_pop & ~o_empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign w_push_ok = i_push & (~o_full | w_pop_ok);

    generate
        if (DEPTH > 1) begin : g_multi
            logic [WIDTH-1:0] r_mem [DEPTH];
            logic [c_IW-1:0]  w_wr_idx;
            logic [c_IW-1:0]  w_rd_idx;

            assign w_wr_idx   = r_wr_ptr[c_IW-1:0];
            assign w_rd_idx   = r_rd_ptr[c_IW-1:0];
            assign o_full     = (r_wr_ptr[c_PW-1] != r_rd_ptr[c_PW-1]) &&
                                (w_wr_idx == w_rd_idx);
            assign o_pop_data = r_mem[w_rd_idx];

            always_ff @(posedge clk) begin
                if (w_push_ok) begin
                    r_mem[w_wr_idx] <= i_push_data;
                end
            end
        end else begin : g_single
            logic [WIDTH-1:0] r_slot;

            assign o_full     = (r_wr_ptr[0] != r_rd_ptr[0]);
            assign o_pop_data = r_slot;

            always_ff @(posedge clk) begin
                if (w_push_ok) begin
                    r_slot <= i_push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ifetch_queue.sv
// ============================================================================
// Module : ifetch_queue
// Brief  : Credit-based instruction fetch queue pairing responses with PCs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int DEPTH     = c_DEPTH,
    parameter int MAX_OUTST = c_MAX_OUTST,
    parameter int ADDR_W    = c_ADDR_W,
    parameter int INSTR_W   = c_INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               pc_req_vld,
    output logic               pc_req_rdy,
    input  logic [ADDR_W-1:0]  pc_req_addr,
    output logic               ch_req_vld,
    input  logic               ch_req_rdy,
    output logic [ADDR_W-1:0]  ch_req_addr,
    input  logic               ch_rsp_vld,
    output logic               ch_rsp_rdy,
    input  logic [INSTR_W-1:0] ch_rsp_instr,
    input  logic               ch_rsp_err,
    output logic               dec_vld,
    input  logic               dec_rdy,
    output logic [ADDR_W-1:0]  dec_pc,
    output logic [INSTR_W-1:0] dec_instr,
    output logic               dec_err
);

    localparam int c_ENT_W     = ADDR_W + INSTR_W + 1;
    localparam int c_ERR_LSB   = 0;
    localparam int c_INSTR_LSB = 1;
    localparam int c_PC_LSB    = 1 + INSTR_W;
    localparam int c_OCC_W     = $clog2(DEPTH) + 1;
    localparam int c_OUT_W     = $clog2(MAX_OUTST) + 1;
    localparam logic [c_OUT_W-1:0] c_OUT_ONE = {{(c_OUT_W-1){1'b0}}, 1'b1};

    logic [c_OUT_W-1:0]          r_outst;
    logic [c_OUT_W-1:0]          r_drop;
    logic                        w_can_req;
    logic                        w_req_hs;
    logic                        w_rsp_hs;
    logic                        w_keep;
    logic [c_OUT_W-1:0]          w_req_inc;
    logic [c_OUT_W-1:0]          w_rsp_dec;
    logic [c_ENT_W-1:0]          w_wr_ent;
    logic [c_ENT_W-1:0]          w_head;
    logic [c_OCC_W-1:0]          w_occ;
    logic                        w_data_empty;
    logic                        w_data_full;
    logic [ADDR_W-1:0]           w_tag_pc;
    logic                        w_tag_empty;
    logic                        w_tag_full;
    logic [$clog2(MAX_OUTST):0]  w_tag_occ;
    logic                        w_unused_ok;

    // Space must already exist for every request in flight plus the new one.
    assign w_can_req = ((int'(w_occ) + int'(r_outst)) < DEPTH) &&
                       (int'(r_outst) < MAX_OUTST) && !flush && !rst;

    assign ch_req_vld  = pc_req_vld & w_can_req;
    assign ch_req_addr = pc_req_addr;
    assign pc_req_rdy  = ch_req_rdy & w_can_req;
    assign ch_rsp_rdy  = 1'b1;

    assign w_req_hs  = pc_req_vld & pc_req_rdy;
    // A response with nothing outstanding (e.g. straggler after reset) is ignored.
    assign w_rsp_hs  = ch_rsp_vld & (r_outst != '0);
    assign w_keep    = w_rsp_hs & (r_drop == '0) & ~flush;
    assign w_req_inc = {{(c_OUT_W-1){1'b0}}, w_req_hs};
    assign w_rsp_dec = {{(c_OUT_W-1){1'b0}}, w_rsp_hs};

    assign w_wr_ent = {w_tag_pc, ch_rsp_instr, ch_rsp_err};

    assign dec_vld   = ~w_data_empty & ~rst;
    assign dec_pc    = w_head[c_PC_LSB +: ADDR_W];
    assign dec_instr = w_head[c_INSTR_LSB +: INSTR_W];
    assign dec_err   = w_head[c_ERR_LSB];

    assign w_unused_ok = ^{w_data_full, w_tag_full, w_tag_occ};

    ifq_sync_fifo #(
        .WIDTH (c_ENT_W),
        .DEPTH (DEPTH)
    ) u_data_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (flush),
        .i_push      (w_keep),
        .i_push_data (w_wr_ent),
        .i_pop       (dec_vld & dec_rdy),
        .o_pop_data  (w_head),
        .o_full      (w_data_full),
        .o_empty     (w_data_empty),
        .o_occ       (w_occ)
    );

    // Tags survive a flush so dropped responses still pop their own PC.
    ifq_sync_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (1'b0),
        .i_push      (w_req_hs),
        .i_push_data (pc_req_addr),
        .i_pop       (w_rsp_hs & ~w_tag_empty),
        .o_pop_data  (w_tag_pc),
        .o_full      (w_tag_full),
        .o_empty     (w_tag_empty),
        .o_occ       (w_tag_occ)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outst <= '0;
            r_drop  <= '0;
        end else begin
            r_outst <= r_outst + w_req_inc - w_rsp_dec;
            if (flush) begin
                r_drop <= r_outst - w_rsp_dec;
            end else if (w_rsp_hs && (r_drop != '0)) begin
                r_drop <= r_drop - c_OUT_ONE;
            end
        end
    end

endmodule

`default_nettype wire
